// File: rtl/irq_enc_pkg.sv
// Shared types and default sizes for the interrupt request encoder.
// Reused by the top-level FSM and its combinational priority encoder.
package irq_enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_DEF = 8;
    localparam int W_DEF = 3;

endpackage

// File: rtl/priority_encoder_8to3.sv
// Combinational priority encoder: index of the winning set bit plus an any-set flag.
// HIGH_FIRST selects whether the most- or least-significant set bit wins.
module priority_encoder_8to3
    import irq_enc_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int W          = W_DEF,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         any
);

    // The last assignment in scan order wins, so scan toward the favoured end.
    always_comb begin
        idx = '0;
        any = |in;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (in[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Registered 8-to-3 interrupt encoder: latches request pulses into a pending
// register, grants one eligible line at a time and holds it until acknowledged.
module irq_encoder_8to3
    import irq_enc_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int W          = W_DEF,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] pending
);

    if (W != $clog2(N)) begin : g_bad_width
        $error("irq_encoder_8to3: W must equal clog2(N)");
    end

    state_t       state, state_next;
    logic [W-1:0] idx_next;
    logic [N-1:0] clr, pending_next, elig, elig_next;
    logic [W-1:0] idx_cur, idx_after_ack;
    logic         any_cur, any_after_ack;

    // Set wins over clear, so a request arriving on the line being acked stays pending.
    assign clr          = (valid && ack) ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    assign pending_next = (pending & ~clr) | req;
    assign elig         = pending & mask;
    assign elig_next    = pending_next & mask;
    assign valid        = (state == GRANT);

    priority_encoder_8to3 #(.N(N), .W(W), .HIGH_FIRST(HIGH_FIRST)) u_penc_cur (
        .in  (elig),
        .idx (idx_cur),
        .any (any_cur)
    );

    priority_encoder_8to3 #(.N(N), .W(W), .HIGH_FIRST(HIGH_FIRST)) u_penc_next (
        .in  (elig_next),
        .idx (idx_after_ack),
        .any (any_after_ack)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (any_cur) begin
                    state_next = GRANT;
                    idx_next   = idx_cur;
                end
            end
            GRANT: begin
                // idx stays frozen until ack; on ack pick the next winner immediately.
                if (ack) begin
                    if (any_after_ack) begin
                        idx_next = idx_after_ack;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Bench for irq_encoder_8to3: directed vector table, hand sequences for the
// low-first variant, and randomized traffic against a reference model.
module tb_irq_encoder_8to3;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic         valid_h, valid_l;
    logic [W-1:0] idx_h, idx_l;
    logic [N-1:0] pend_h, pend_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    irq_encoder_8to3 #(.N(N), .W(W), .HIGH_FIRST(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .valid(valid_h), .idx(idx_h), .pending(pend_h)
    );

    irq_encoder_8to3 #(.N(N), .W(W), .HIGH_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .valid(valid_l), .idx(idx_l), .pending(pend_l)
    );

    // Reference model: [0] for the high-first instance, [1] for low-first.
    bit [N-1:0] m_pend [2];
    bit         m_valid [2];
    int         m_idx [2];

    function automatic int pick(bit [N-1:0] v, bit hf);
        int r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i] && (hf || r < 0)) r = i;
        end
        return r;
    endfunction

    task automatic model_step(int k, bit hf);
        bit [N-1:0] nxt;
        bit served;
        if (!rst_n) begin
            m_pend[k]  = '0;
            m_valid[k] = 1'b0;
            m_idx[k]   = 0;
            return;
        end
        served = m_valid[k] && ack;
        nxt = m_pend[k];
        if (served) nxt[m_idx[k]] = 1'b0;
        nxt = nxt | req;
        if (!m_valid[k]) begin
            if ((m_pend[k] & mask) != 0) begin
                m_valid[k] = 1'b1;
                m_idx[k]   = pick(m_pend[k] & mask, hf);
            end
        end else if (served) begin
            if ((nxt & mask) != 0) m_idx[k] = pick(nxt & mask, hf);
            else m_valid[k] = 1'b0;
        end
        m_pend[k] = nxt;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        #1;
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        chk({tag, " hi valid"},   int'(valid_h), int'(m_valid[0]));
        chk({tag, " hi idx"},     int'(idx_h),   m_idx[0]);
        chk({tag, " hi pending"}, int'(pend_h),  int'(m_pend[0]));
        chk({tag, " lo valid"},   int'(valid_l), int'(m_valid[1]));
        chk({tag, " lo idx"},     int'(idx_l),   m_idx[1]);
        chk({tag, " lo pending"}, int'(pend_l),  int'(m_pend[1]));
    endtask

    typedef struct {
        bit       rst_n;
        bit [7:0] req;
        bit [7:0] mask;
        bit       ack;
        bit       ev;
        int       ei;
        bit [7:0] ep;
    } vec_t;

    vec_t tv [$];

    task automatic add(bit r, bit [7:0] rq, bit [7:0] m, bit a, bit ev, int ei, bit [7:0] ep);
        vec_t v;
        v.rst_n = r; v.req = rq; v.mask = m; v.ack = a;
        v.ev = ev; v.ei = ei; v.ep = ep;
        tv.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask = 8'hFF; ack = 1'b0;

        // Expected outputs of the high-first instance after each edge.
        add(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00);
        add(0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) add(1, 8'h00, 8'hFF, 0, 0, 0, 8'h00);
        add(1, 8'h24, 8'hFF, 0, 0, 0, 8'h24);
        add(1, 8'h00, 8'hFF, 0, 1, 5, 8'h24);
        add(1, 8'h80, 8'hFF, 0, 1, 5, 8'hA4);
        for (int i = 0; i < 3; i++) add(1, 8'h00, 8'hFF, 0, 1, 5, 8'hA4);
        add(1, 8'h00, 8'hFF, 1, 1, 7, 8'h84);
        add(1, 8'h00, 8'hFF, 1, 1, 2, 8'h04);
        add(1, 8'h00, 8'hFF, 1, 0, 2, 8'h00);
        add(1, 8'hF0, 8'h0F, 0, 0, 2, 8'hF0);
        add(1, 8'h00, 8'h0F, 0, 0, 2, 8'hF0);
        add(1, 8'h00, 8'hFF, 0, 1, 7, 8'hF0);
        add(1, 8'h00, 8'hFF, 1, 1, 6, 8'h70);
        add(1, 8'h00, 8'hFF, 1, 1, 5, 8'h30);
        add(1, 8'h00, 8'hFF, 1, 1, 4, 8'h10);
        add(1, 8'h00, 8'hFF, 1, 0, 4, 8'h00);
        add(1, 8'h08, 8'hFF, 0, 0, 4, 8'h08);
        add(1, 8'h00, 8'hFF, 0, 1, 3, 8'h08);
        add(1, 8'h08, 8'hFF, 1, 1, 3, 8'h08);
        add(1, 8'h00, 8'hFF, 1, 0, 3, 8'h00);
        add(1, 8'h24, 8'hFF, 0, 0, 3, 8'h24);
        add(1, 8'h00, 8'hFF, 0, 1, 5, 8'h24);
        add(0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
        add(1, 8'h00, 8'hFF, 0, 0, 0, 8'h00);
        add(1, 8'h00, 8'hFF, 1, 0, 0, 8'h00);
        add(1, 8'h01, 8'hFF, 1, 0, 0, 8'h01);
        add(1, 8'h00, 8'hFF, 0, 1, 0, 8'h01);
        add(1, 8'h00, 8'hFF, 1, 0, 0, 8'h00);

        foreach (tv[i]) begin
            rst_n = tv[i].rst_n; req = tv[i].req; mask = tv[i].mask; ack = tv[i].ack;
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl valid", i),   int'(valid_h), int'(tv[i].ev));
            chk($sformatf("vec%0d tbl idx", i),     int'(idx_h),   tv[i].ei);
            chk($sformatf("vec%0d tbl pending", i), int'(pend_h),  int'(tv[i].ep));
        end

        // Low-first instance: same request pattern grants bit 2 first, then 5.
        rst_n = 1'b0; req = '0; mask = 8'hFF; ack = 1'b0;
        cycle("lf rst");
        rst_n = 1'b1; req = 8'h24;
        cycle("lf req");
        req = 8'h00;
        cycle("lf wait");
        chk("lf first valid", int'(valid_l), 1);
        chk("lf first idx",   int'(idx_l),   2);
        chk("hf first idx",   int'(idx_h),   5);
        ack = 1'b1;
        cycle("lf ack1");
        chk("lf second idx", int'(idx_l), 5);
        chk("hf second idx", int'(idx_h), 2);
        cycle("lf ack2");
        chk("lf drained valid",   int'(valid_l), 0);
        chk("lf drained pending", int'(pend_l),  0);
        ack = 1'b0;

        // Randomized traffic with occasional resets and mask closures.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            req   = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            ack   = 1'($urandom_range(0, 1));
            cycle($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
